// File: rtl/timer_ctrl_pkg.sv
// Shared types and helpers for the stopwatch/countdown run controller.
//   run_state_e  : controller state, IDLE=0 RUNNING=1 PAUSED=2 EXPIRED=3
//   MODE_A/MODE_B: mode_sel values (count-up / countdown)
//   presc_limit(): last prescaler count (divider - 1) for a mode
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } run_state_e;

  localparam logic MODE_A = 1'b0;
  localparam logic MODE_B = 1'b1;

  // Terminal prescaler count for the selected mode.
  function automatic int unsigned presc_limit(input logic mode,
                                              input int unsigned div_a,
                                              input int unsigned div_b);
    int unsigned div;
    div = div_a;
    case (mode)
      MODE_A:  div = div_a;
      MODE_B:  div = div_b;
      default: div = div_a;
    endcase
    return div - 1;
  endfunction

endpackage

// File: rtl/timer_run_controller_if.sv
// Control link between the run controller and the timer core.
//   core_tick : one-cycle count enable to the core
//   core_clr  : one-cycle synchronous clear to the core
//   core_done : core stop condition (limit reached), level
// master = run controller, slave = timer core.
interface timer_run_controller_if;

  logic core_tick;
  logic core_clr;
  logic core_done;

  modport master (
    output core_tick,
    output core_clr,
    input  core_done
  );

  modport slave (
    input  core_tick,
    input  core_clr,
    output core_done
  );

endinterface

// File: rtl/timer_run_controller_button_debouncer.sv
// Start/Stop button conditioning: 2-flop synchronizer, debounce counter and
// rising-edge detector on the accepted level.
//   clk, rst    : system clock, synchronous active-high reset
//   btn         : raw asynchronous button, active-high
//   press_pulse : registered one-cycle pulse when the accepted level rises
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press_pulse
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q;
  logic            sync2_q;
  logic            level_q;
  logic [DB_W-1:0] cnt_q;
  logic            press_q;

  // Synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
    end
  end

  // Count consecutive samples that disagree with the accepted level; any
  // agreeing sample restarts the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (sync2_q != level_q) begin
        if (cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= sync2_q;
          cnt_q   <= '0;
          press_q <= sync2_q;
        end else begin
          cnt_q <= cnt_q + DB_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_pulse = press_q;

endmodule

// File: rtl/timer_run_controller.sv
// Front-panel run controller: sequences the timer core through
// IDLE/RUNNING/PAUSED/EXPIRED, generates the per-mode count tick, clears the
// core on configuration changes and blinks the expiry LED.
//   clk, rst      : system clock, synchronous active-high reset
//   btn_startstop : raw Start/Stop button
//   mode_sel      : 0 = count-up mode, 1 = countdown mode
//   time_ctrl     : countdown preset, watched for changes only
//   core          : tick/clear/done link to the timer core (master side)
//   running       : high while RUNNING
//   state         : current state encoding
//   led_expired   : blinking expiry indicator
module timer_run_controller
  import timer_ctrl_pkg::*;
#(
  parameter int unsigned DIV_A           = 500000,
  parameter int unsigned DIV_B           = 50000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLINK_DIV       = 12500000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   btn_startstop,
  input  logic                   mode_sel,
  input  logic [2:0]             time_ctrl,
  timer_run_controller_if.master core,
  output logic                   running,
  output logic [1:0]             state,
  output logic                   led_expired
);

  localparam int unsigned DIV_MAX = (DIV_A > DIV_B) ? DIV_A : DIV_B;
  localparam int unsigned CNT_W   = (DIV_MAX > 2) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  run_state_e         state_q;
  run_state_e         state_d;
  logic               press;
  logic               mode_q;
  logic [2:0]         tc_q;
  logic               cfg_change_c;
  logic [CNT_W-1:0]   limit_c;
  logic [CNT_W-1:0]   presc_q;
  logic [CNT_W-1:0]   presc_d;
  logic               tick_c;
  logic               clr_c;
  logic               tick_q;
  logic               clr_q;
  logic               running_q;
  logic               led_q;
  logic [BLINK_W-1:0] blink_q;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk        (clk),
    .rst        (rst),
    .btn        (btn_startstop),
    .press_pulse(press)
  );

  // Configuration change against the previous-cycle snapshot
  assign cfg_change_c = (mode_sel != mode_q) || (time_ctrl != tc_q);
  assign limit_c      = CNT_W'(presc_limit(mode_sel, DIV_A, DIV_B));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: config change beats core_done beats press
  always_comb begin
    state_d = state_q;
    if (cfg_change_c) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (press) state_d = ST_RUNNING;
        ST_RUNNING: begin
          if (core.core_done) state_d = ST_EXPIRED;
          else if (press)     state_d = ST_PAUSED;
        end
        ST_PAUSED:  if (press) state_d = ST_RUNNING;
        ST_EXPIRED: if (press) state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs and prescaler next value
  always_comb begin
    tick_c  = 1'b0;
    clr_c   = 1'b0;
    presc_d = presc_q;
    if (cfg_change_c || (state_q == ST_EXPIRED && press)) clr_c = 1'b1;
    // A done or config-change cycle neither ticks nor advances the period
    if (state_q == ST_RUNNING && !cfg_change_c && !core.core_done) begin
      if (presc_q == limit_c) begin
        tick_c  = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + CNT_W'(1);
      end
    end
    if (state_d == ST_IDLE) presc_d = '0;
  end

  // Registered outputs, prescaler and configuration snapshot
  always_ff @(posedge clk) begin
    mode_q <= mode_sel;
    tc_q   <= time_ctrl;
    if (rst) begin
      presc_q   <= '0;
      tick_q    <= 1'b0;
      clr_q     <= 1'b0;
      running_q <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      tick_q    <= tick_c;
      clr_q     <= clr_c;
      running_q <= (state_d == ST_RUNNING);
    end
  end

  // Expiry blink: on at entry, toggles every BLINK_DIV cycles, off on exit
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q   <= 1'b0;
      blink_q <= '0;
    end else if (state_d == ST_EXPIRED) begin
      if (state_q != ST_EXPIRED) begin
        led_q   <= 1'b1;
        blink_q <= '0;
      end else if (blink_q == BLINK_W'(BLINK_DIV - 1)) begin
        led_q   <= ~led_q;
        blink_q <= '0;
      end else begin
        blink_q <= blink_q + BLINK_W'(1);
      end
    end else begin
      led_q   <= 1'b0;
      blink_q <= '0;
    end
  end

  assign core.core_tick = tick_q;
  assign core.core_clr  = clr_q;
  assign running        = running_q;
  assign state          = state_q;
  assign led_expired    = led_q;

endmodule

// File: tb/tb_timer_run_controller.sv
// Randomized bench for timer_run_controller with a behavioural model and a
// scoreboard queue drained by an independent monitor.
module tb_timer_run_controller;

  localparam int unsigned DIV_A    = 4;
  localparam int unsigned DIV_B    = 10;
  localparam int unsigned DB       = 3;
  localparam int unsigned BLINK    = 5;
  localparam int          N_CYCLES = 4000;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_PAUS = 2;
  localparam int S_EXP  = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       mode_sel;
  logic [2:0] time_ctrl;
  logic       running;
  logic [1:0] state;
  logic       led;

  timer_run_controller_if core_bus ();

  timer_run_controller #(
    .DIV_A          (DIV_A),
    .DIV_B          (DIV_B),
    .DEBOUNCE_CYCLES(DB),
    .BLINK_DIV      (BLINK)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_startstop(btn),
    .mode_sel     (mode_sel),
    .time_ctrl    (time_ctrl),
    .core         (core_bus),
    .running      (running),
    .state        (state),
    .led_expired  (led)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [1:0] state;
    logic       running;
    logic       tick;
    logic       clr;
    logic       led;
  } exp_t;

  exp_t sb_q[$];
  int   n_compared   = 0;
  int   n_mismatched = 0;

  // Behavioural model state
  int         m_state = S_IDLE;
  int         m_run   = 0;     // RUNNING cycles since the last clear
  int         m_age   = 0;     // cycles spent in EXPIRED
  logic       m_press = 1'b0;  // press visible to the controller this cycle
  logic       m_level = 1'b0;  // accepted button level
  logic       raw_q[$];        // raw samples still inside the synchronizer
  logic       samp_q[$];       // most recent synchronized samples
  logic       m_prev_mode = 1'b0;
  logic [2:0] m_prev_tc   = 3'd0;

  // Advance the model across one rising edge and return the outputs after it.
  task automatic model_step(input logic r, input logic b, input logic ms,
                            input logic [2:0] tc, input logic done,
                            input int cyc, output exp_t e);
    int   nxt;
    int   div;
    logic cfg;
    logic tick;
    logic clr;
    logic led_v;
    logic s;
    logic flip;
    e.cyc = cyc;
    if (r) begin
      m_state = S_IDLE;
      m_run   = 0;
      m_age   = 0;
      m_press = 1'b0;
      m_level = 1'b0;
      raw_q   = '{1'b0, 1'b0};
      samp_q.delete();
      m_prev_mode = ms;
      m_prev_tc   = tc;
      e.state = 2'd0; e.running = 1'b0; e.tick = 1'b0; e.clr = 1'b0; e.led = 1'b0;
    end else begin
      cfg  = (ms != m_prev_mode) || (tc != m_prev_tc);
      div  = ms ? int'(DIV_B) : int'(DIV_A);
      nxt  = m_state;
      tick = 1'b0;
      clr  = 1'b0;
      if (cfg) begin
        nxt = S_IDLE;
        clr = 1'b1;
      end else begin
        case (m_state)
          S_RUN: begin
            if (done) nxt = S_EXP;
            else begin
              m_run++;
              tick = (m_run % div) == 0;
              if (m_press) nxt = S_PAUS;
            end
          end
          S_IDLE: if (m_press) nxt = S_RUN;
          S_PAUS: if (m_press) nxt = S_RUN;
          default: if (m_press) begin nxt = S_IDLE; clr = 1'b1; end
        endcase
      end
      if (nxt == S_IDLE) m_run = 0;
      if (nxt == S_EXP) begin
        m_age = (m_state == S_EXP) ? m_age + 1 : 0;
        led_v = ((m_age / int'(BLINK)) % 2) == 0;
      end else begin
        m_age = 0;
        led_v = 1'b0;
      end
      // Button: a level is accepted once DB synchronized samples all differ
      s = raw_q.pop_front();
      raw_q.push_back(b);
      samp_q.push_back(s);
      if (samp_q.size() > int'(DB)) void'(samp_q.pop_front());
      flip = (samp_q.size() == int'(DB));
      foreach (samp_q[i]) if (samp_q[i] == m_level) flip = 1'b0;
      m_press = flip && !m_level;
      if (flip) m_level = ~m_level;
      m_prev_mode = ms;
      m_prev_tc   = tc;
      m_state     = nxt;
      e.state   = 2'(nxt);
      e.running = (nxt == S_RUN);
      e.tick    = tick;
      e.clr     = clr;
      e.led     = led_v;
    end
  endtask

  // Stimulus
  initial begin : stim
    logic btn_plan[$];
    exp_t e;
    logic due;
    int   r;
    int   n;
    rst       = 1'b1;
    btn       = 1'b0;
    mode_sel  = 1'b0;
    time_ctrl = 3'b001;
    core_bus.core_done = 1'b0;
    for (int c = 0; c < N_CYCLES; c++) begin
      @(negedge clk);
      rst = (c < 3) || ($urandom_range(0, 799) == 0);
      if (btn_plan.size() == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          repeat (5) begin
            btn_plan.push_back(1'b1);
            btn_plan.push_back(1'b0);
            btn_plan.push_back(1'b0);
          end
        end else begin
          n = $urandom_range(2, 12);
          repeat (n) btn_plan.push_back(1'b1);
          n = $urandom_range(4, 16);
          repeat (n) btn_plan.push_back(1'b0);
        end
      end
      btn = btn_plan.pop_front();
      r = $urandom_range(0, 149);
      if (r == 0)      mode_sel  = ~mode_sel;
      else if (r == 1) time_ctrl = 3'($urandom_range(0, 7));
      due = (m_state == S_RUN) &&
            (((m_run + 1) % (mode_sel ? int'(DIV_B) : int'(DIV_A))) == 0);
      core_bus.core_done = due ? ($urandom_range(0, 7) == 0)
                               : ($urandom_range(0, 99) == 0);
      model_step(rst, btn, mode_sel, time_ctrl, core_bus.core_done, c, e);
      sb_q.push_back(e);
    end
    @(posedge clk);
    #4;
    n_compared++;
    if (sb_q.size() != 0) begin
      n_mismatched++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  // Monitor: compare DUT outputs after every edge against the queued model
  initial begin : mon
    exp_t       e;
    logic [5:0] got;
    logic [5:0] want;
    forever begin
      @(posedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e    = sb_q.pop_front();
        got  = {state, running, core_bus.core_tick, core_bus.core_clr, led};
        want = {e.state, e.running, e.tick, e.clr, e.led};
        n_compared++;
        if (got !== want) begin
          n_mismatched++;
          $display("FAIL outputs cycle %0d: got state=%0d running=%0b tick=%0b clr=%0b led=%0b, required state=%0d running=%0b tick=%0b clr=%0b led=%0b",
                   e.cyc, state, running, core_bus.core_tick, core_bus.core_clr, led,
                   e.state, e.running, e.tick, e.clr, e.led);
        end
      end
    end
  end

endmodule
